// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divider issue controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    DRAIN,
    DONE
  } div_state_e;

  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;

  // DIV/REM are signed, DIVU/REMU are unsigned.
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/div_reuse_match.sv
// Remembers the operands/sign/kind of the last completed divide and flags a
// request that can take its result from the companion DIV/REM output.
module div_reuse_match #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            capture_i,
  input  logic            commit_i,
  input  logic            clear_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            hit_o
);

  logic            pend_signed_q, pend_rem_q;
  logic [XLEN-1:0] pend_rs1_q, pend_rs2_q;
  logic            last_valid_q, last_signed_q, last_rem_q;
  logic [XLEN-1:0] last_rs1_q, last_rs2_q;

  // Operands are captured at issue, promoted to "last" only once the op completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_signed_q <= 1'b0;
      pend_rem_q    <= 1'b0;
      pend_rs1_q    <= '0;
      pend_rs2_q    <= '0;
      last_valid_q  <= 1'b0;
      last_signed_q <= 1'b0;
      last_rem_q    <= 1'b0;
      last_rs1_q    <= '0;
      last_rs2_q    <= '0;
    end else begin
      if (capture_i) begin
        pend_signed_q <= signed_i;
        pend_rem_q    <= rem_i;
        pend_rs1_q    <= rs1_i;
        pend_rs2_q    <= rs2_i;
      end
      if (commit_i) begin
        last_signed_q <= pend_signed_q;
        last_rem_q    <= pend_rem_q;
        last_rs1_q    <= pend_rs1_q;
        last_rs2_q    <= pend_rs2_q;
      end
      if (clear_i) begin
        last_valid_q <= 1'b0;
      end else if (commit_i) begin
        last_valid_q <= 1'b1;
      end
    end
  end

  assign hit_o = last_valid_q && (signed_i == last_signed_q) && (rem_i != last_rem_q)
                 && (rs1_i == last_rs1_q) && (rs2_i == last_rs2_q);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller for the RV32M iterative divider cores.
// Optional DIV/REM result reuse is enabled by defining DIV_FUSE_EN.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            rv32m,
  input  logic [2:0]      func3,
  input  logic            fuse,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            div_done,
  output logic            start_sdivide,
  output logic            start_udivide,
  output logic            op_is_rem,
  output logic            stall,
  output logic            res_valid,
  output logic            reused,
  output logic            div_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             rem_q, rem_d;
  logic             start_s_q, start_s_d;
  logic             start_u_q, start_u_d;
  logic             res_q, res_d;
  logic             reused_q, reused_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;

  logic req, go, sgn_now, accept, reuse_hit, timeout;

  assign req     = id_valid & rv32m & func3[2] & ~fuse;
  assign go      = req & ~flush;
  assign sgn_now = f3_is_signed(func3);
  assign timeout = (cnt_q == CNT_LAST);

`ifdef DIV_FUSE_EN
  logic match_commit, match_clear;

  assign match_commit = (state_q == DONE);
  assign match_clear  = flush | err_d | (accept & ~reuse_hit);

  div_reuse_match #(
    .XLEN(XLEN)
  ) u_match (
    .clk_i     (clk),
    .rst_i     (rst),
    .capture_i (accept),
    .commit_i  (match_commit),
    .clear_i   (match_clear),
    .signed_i  (sgn_now),
    .rem_i     (func3[1]),
    .rs1_i     (rs1_val),
    .rs2_i     (rs2_val),
    .hit_o     (reuse_hit)
  );
`else
  logic unused_ops;

  assign reuse_hit  = 1'b0;
  assign unused_ops = ^{rs1_val, rs2_val};
`endif

  // The counter is zeroed on entry to START and runs through START/BUSY/DRAIN,
  // so the abort lands TIMEOUT_CYCLES cycles after the start pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    rem_d     = rem_q;
    start_s_d = 1'b0;
    start_u_d = 1'b0;
    reused_d  = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          accept = 1'b1;
          sgn_d  = sgn_now;
          rem_d  = func3[1];
          if (reuse_hit) begin
            state_d  = DONE;
            reused_d = 1'b1;
          end else begin
            state_d   = START;
            cnt_d     = '0;
            start_s_d = sgn_now;
            start_u_d = ~sgn_now;
          end
        end
      end
      START: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = flush ? DRAIN : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_done) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_done) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    res_d   = (state_d == DONE);
    stall_d = (state_d == START) || (state_d == BUSY) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= 1'b0;
      start_s_q <= 1'b0;
      start_u_q <= 1'b0;
      res_q     <= 1'b0;
      reused_q  <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      rem_q     <= rem_d;
      start_s_q <= start_s_d;
      start_u_q <= start_u_d;
      res_q     <= res_d;
      reused_q  <= reused_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
    end
  end

  assign start_sdivide = start_s_q;
  assign start_udivide = start_u_q;
  assign op_is_rem     = rem_q;
  assign res_valid     = res_q;
  assign reused        = reused_q;
  assign div_err       = err_q;
  assign stall         = stall_q | (~rst & (state_q == IDLE) & go);

endmodule
